// File: rtl/ff_pkg.sv
// Shared JK flip-flop command encodings, indexed as {j, k}.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ff_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_bit_cell.sv
// Next-state function of one JK bit with parallel-load override, plus edge flags.
// Latency: purely combinational.
// Backpressure: none.
module jk_bit_cell
    import ff_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    input  logic en,
    input  logic load,
    input  logic d,
    output logic q_next,
    output logic rise_next,
    output logic fall_next
);

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = d;
        end else if (en) begin
            case ({j, k})
                JK_HOLD: q_next = q;
                JK_CLR:  q_next = 1'b0;
                JK_SET:  q_next = 1'b1;
                JK_TOG:  q_next = ~q;
                default: q_next = q;
            endcase
        end
        rise_next = ~q & q_next;
        fall_next = q & ~q_next;
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with shared enable, parallel load and registered edge flags.
// Latency: one cycle from inputs to q/rise/fall/any_change; q_bar is combinational from q.
// Backpressure: none; every edge accepts new inputs.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_bit_cell u_cell (
            .q         (q[i]),
            .j         (j[i]),
            .k         (k[i]),
            .en        (en),
            .load      (load),
            .d         (d[i]),
            .q_next    (q_next[i]),
            .rise_next (rise_next[i]),
            .fall_next (fall_next[i])
        );
    end

    // Reset never reports an edge, even when it changes q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q          <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            q          <= q_next;
            rise       <= rise_next;
            fall       <= fall_next;
            any_change <= |(rise_next | fall_next);
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: directed scenarios then random traffic,
// expected outputs from a bitwise characteristic-equation model.
module tb_jk_reg_bank;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic [7:0] q, q_bar, rise, fall;
    logic       any_change;

    exp_t       sb_q[$];
    logic [7:0] mq;
    int         tests = 0;
    int         fails = 0;
    bit         stim_done = 1'b0;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .load       (load),
        .d          (d),
        .j          (j),
        .k          (k),
        .q          (q),
        .q_bar      (q_bar),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the next edge.
    task automatic step(input bit rst, input bit ld, input bit e,
                        input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd);
        exp_t       x;
        logic [7:0] nq;
        @(negedge clk);
        reset_n = ~rst;
        load    = ld;
        en      = e;
        j       = jj;
        k       = kk;
        d       = dd;
        if (rst) begin
            nq     = RV;
            x.rise = '0;
            x.fall = '0;
            x.any  = 1'b0;
        end else begin
            if (ld)     nq = dd;
            else if (e) nq = (jj & ~mq) | (~kk & mq);
            else        nq = mq;
            x.rise = ~mq & nq;
            x.fall = mq & ~nq;
            x.any  = (mq != nq);
        end
        x.q = nq;
        mq  = nq;
        sb_q.push_back(x);
    endtask

    // Monitor: outputs are compared just after every edge that has a pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("q", q, x.q);
                check("q_bar", q_bar, ~x.q);
                check("rise", rise, x.rise);
                check("fall", fall, x.fall);
                check("any_change", {7'b0, any_change}, {7'b0, x.any});
            end
        end
    end

    initial begin
        int n;
        mq = 'x;
        // 1: reset with random inputs
        repeat (2) step(1, $urandom_range(0, 1), 1, 8'($urandom), 8'($urandom), 8'($urandom));
        // 2: set/clear from A5, then quiet
        step(0, 0, 1, 8'hF0, 8'h0F, 8'h00);
        step(0, 0, 1, 8'h00, 8'h00, 8'h00);
        // 3: toggle three times
        repeat (3) step(0, 0, 1, 8'hFF, 8'hFF, 8'h00);
        // 4: enable low
        repeat (2) step(0, 0, 0, 8'hFF, 8'h00, 8'h00);
        // 5: load wins over toggle, then same value again
        step(0, 1, 1, 8'hFF, 8'hFF, 8'h3C);
        step(0, 1, 1, 8'hFF, 8'hFF, 8'h3C);
        // 6: reset with load while toggling, then release
        step(0, 0, 1, 8'hFF, 8'hFF, 8'h00);
        step(1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
        step(0, 0, 1, 8'h01, 8'h00, 8'h00);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        step(0, 0, 0, 8'h00, 8'h00, 8'h00);
        stim_done = 1'b1;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
